// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch block     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_FULL = 3'd2,
    S_DROP = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] c_nop_instr        = 32'h0000_0013;
  localparam logic [31:0] c_default_reset_pc = 32'h0040_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_cnt.sv
// +----------------------------------------------------------------------------+
// | fetch_timeout_cnt : saturating wait counter with clear, enable and         |
// |                     terminal-count flag                                    |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] c_tc = W'(TIMEOUT_CYC);

  logic [W-1:0] r_cnt;

  // Holds at the terminal count so the flag stays asserted until cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_tc)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == c_tc);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// +----------------------------------------------------------------------------+
// | instr_fetch_ctrl : PC-to-imem fetch controller with one-entry output reg,  |
// |                    flush dropping and memory timeout.                      |
// |                    FETCH_ALIGN_CHECK_EN enables the misaligned-PC trap.    |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = c_default_reset_pc,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic        o_pc_en,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_fetch_err,
  output logic        o_misalign
);

  fetch_state_t r_state;
  logic [31:0]  r_imem_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_instr_valid;
  logic         r_fetch_err;
  logic         r_misalign;

  logic w_waiting;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_tc;
  logic w_pc_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_pc_misaligned = |i_pc[1:0];
`else
  assign w_pc_misaligned = 1'b0;
`endif

  assign w_waiting = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_cnt_clr = i_imem_ack || !w_waiting;
  // A flush cycle does not count toward the timeout.
  assign w_cnt_en  = w_waiting && !i_imem_ack && !i_flush;

  fetch_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_imem_addr   <= RESET_PC;
      r_instr       <= c_nop_instr;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_flush) begin
            if (w_pc_misaligned) begin
              r_misalign <= 1'b1;
              r_state    <= S_ERR;
            end else begin
              r_imem_addr <= i_pc;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_flush) begin
            r_state <= i_imem_ack ? S_IDLE : S_DROP;
          end else if (i_imem_ack) begin
            r_instr       <= i_imem_rdata;
            r_instr_pc    <= r_imem_addr;
            r_instr_valid <= 1'b1;
            r_state       <= S_FULL;
          end else if (w_tc) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_ERR;
          end
        end
        // The request stays up until memory answers; the data is thrown away.
        S_DROP: begin
          if (i_imem_ack) begin
            r_state <= S_IDLE;
          end else if (w_tc && !i_flush) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_ERR;
          end
        end
        S_FULL: begin
          if (i_flush) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else if (r_instr_valid && i_instr_ready) begin
            r_instr_valid <= 1'b0;
            r_imem_addr   <= i_pc;
            r_state       <= S_REQ;
          end
        end
        S_ERR: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pc_en       = (r_state != S_ERR) &&
                         (((r_state == S_REQ) && i_imem_ack) || i_flush);
  assign o_imem_req    = w_waiting;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_err   = r_fetch_err;
  assign o_misalign    = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_instr_fetch_ctrl : directed self-checking bench for instr_fetch_ctrl    |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;
  logic        misalign;

  logic [31:0] pc_init;
  logic [31:0] flush_tgt;

  int n_vec;
  int n_bad;

  instr_fetch_ctrl u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc          (pc),
    .o_pc_en       (pc_en),
    .i_flush       (flush),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_fetch_err   (fetch_err),
    .o_misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: +4 on a completed fetch, redirect target on flush.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= pc_init;
    else if (pc_en) pc <= flush ? flush_tgt : pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst_n       = 1'b1;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_init     = 32'h0040_0000;
    flush_tgt   = 32'h0040_0100;
    #1 rst_n = 1'b0;
    step(); step();

    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0040_0000);
    chk("rst_instr", instr,                32'h0000_0013);
    chk("rst_ipc",   instr_pc,             32'h0040_0000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err",   {31'd0, fetch_err},   32'd0);
    chk("rst_mis",   {31'd0, misalign},    32'd0);

    rst_n = 1'b1;
    #1 chk("cyc1_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("cyc2_req",  {31'd0, imem_req}, 32'd1);
    chk("cyc2_addr", imem_addr,         32'h0040_0000);

    // Zero-wait fetch with decode ready
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    #1 chk("f1_pcen", {31'd0, pc_en}, 32'd1);
    step();
    imem_ack = 1'b0;
    #1;
    chk("f1_valid", {31'd0, instr_valid}, 32'd1);
    chk("f1_instr", instr,                32'h0050_0093);
    chk("f1_ipc",   instr_pc,             32'h0040_0000);
    chk("f1_req",   {31'd0, imem_req},    32'd0);
    chk("f1_pcen0", {31'd0, pc_en},       32'd0);
    step();
    chk("f2_req",   {31'd0, imem_req},    32'd1);
    chk("f2_addr",  imem_addr,            32'h0040_0004);
    chk("f2_valid", {31'd0, instr_valid}, 32'd0);

    // Decode stalls for five cycles
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0113; instr_ready = 1'b0;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr,                32'h00A0_0113);
      chk("stall_req",   {31'd0, imem_req},    32'd0);
      chk("stall_pcen",  {31'd0, pc_en},       32'd0);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr,         32'h0040_0008);

    // Flush while the request is outstanding, late ack
    instr_ready = 1'b0;
    flush = 1'b1;
    #1 chk("fl_pcen", {31'd0, pc_en}, 32'd1);
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drop_req",   {31'd0, imem_req},    32'd1);
      chk("drop_addr",  imem_addr,            32'h0040_0008);
      chk("drop_valid", {31'd0, instr_valid}, 32'd0);
      if (i < 2) step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1 chk("drop_pcen", {31'd0, pc_en}, 32'd0);
    step();
    imem_ack = 1'b0;
    #1;
    chk("dack_req",   {31'd0, imem_req},    32'd0);
    chk("dack_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("redir_req",  {31'd0, imem_req},    32'd1);
    chk("redir_addr", imem_addr,            32'h0040_0100);
    chk("redir_valid",{31'd0, instr_valid}, 32'd0);

    // Memory never answers
    repeat (250) step();
    chk("to_early_err", {31'd0, fetch_err}, 32'd0);
    chk("to_early_req", {31'd0, imem_req},  32'd1);
    repeat (10) step();
    chk("to_err",  {31'd0, fetch_err}, 32'd1);
    chk("to_req",  {31'd0, imem_req},  32'd0);
    flush = 1'b1;
    #1 chk("err_pcen", {31'd0, pc_en}, 32'd0);
    step();
    flush = 1'b0;
    chk("err_hold",  {31'd0, fetch_err},   32'd1);
    chk("err_req",   {31'd0, imem_req},    32'd0);
    chk("err_valid", {31'd0, instr_valid}, 32'd0);

    // Reset clears the error; restart from a misaligned PC
    pc_init = 32'h0040_0002;
    rst_n = 1'b0;
    #1;
    chk("rr_err",   {31'd0, fetch_err}, 32'd0);
    chk("rr_req",   {31'd0, imem_req},  32'd0);
    chk("rr_addr",  imem_addr,          32'h0040_0000);
    chk("rr_instr", instr,              32'h0000_0013);
    step();
    rst_n = 1'b1;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_req",  {31'd0, imem_req}, 32'd0);
    step(); step();
    chk("mis_req2", {31'd0, imem_req}, 32'd0);
    chk("mis_hold", {31'd0, misalign}, 32'd1);
`else
    chk("mis_flag", {31'd0, misalign}, 32'd0);
    chk("mis_req",  {31'd0, imem_req}, 32'd1);
    chk("mis_addr", imem_addr,         32'h0040_0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
